// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
//   AHB-Lite initiator. Turns a valid/ready command stream into single
//   NONSEQ transfers (HBURST=SINGLE). The address phase (stage A) and the
//   data phase (stage D) are pipelined, so zero-wait slaves see one transfer
//   per cycle. Wait states stall both stages. A two-cycle ERROR response
//   cancels the pipelined follower and reissues it once the error finishes.
//
// Ports
//   HCLK, HRESETn      bus clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake; accepted when both are high
//   cmd_write          1 = write, 0 = read
//   cmd_addr/size      byte address and HSIZE (naturally aligned, <= word)
//   cmd_wdata          write data, already positioned on its byte lanes
//   rsp_valid          one-cycle pulse per accepted command, in order
//   rsp_rdata/err      read data (0 for writes) / ERROR response seen
//   busy               a transfer is in its address or data phase
//   H*                 AHB-Lite initiator signals
module ahb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_NONSEQ = 2'b10
    } htrans_e;

    // ST_CANCEL spans the second ERROR cycle: the address phase in A is
    // withdrawn (HTRANS=IDLE) and will be reissued afterwards.
    typedef enum logic {
        ST_RUN,
        ST_CANCEL
    } state_e;

    state_e state, state_nxt;

    logic                  a_valid;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [2:0]            a_size;
    logic [DATA_WIDTH-1:0] a_wdata;

    logic                  d_valid;
    logic                  d_write;
    logic [DATA_WIDTH-1:0] hwdata_q;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic cancel;
    logic resp_err;
    logic advance;
    logic complete;
    logic accept;

    always_comb begin
        cancel    = (state == ST_CANCEL);
        resp_err  = (HRESP != 2'b00);
        advance   = HREADY && !cancel;
        complete  = d_valid && HREADY;
        cmd_ready = !a_valid || (HREADY && !cancel && !(d_valid && resp_err));
        accept    = cmd_valid && cmd_ready;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (d_valid && !HREADY && resp_err) state_nxt = ST_CANCEL;
            ST_CANCEL: if (HREADY) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Stage A reloads whenever it moves on or is empty; an empty A accepts a
    // command even while D is stalled, so idle commands land straight in A.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_addr  <= '0;
            a_size  <= '0;
            a_wdata <= '0;
        end else if (advance || !a_valid) begin
            a_valid <= accept;
            if (accept) begin
                a_write <= cmd_write;
                a_addr  <= cmd_addr;
                a_size  <= cmd_size;
                a_wdata <= cmd_wdata;
            end
        end
    end

    // Stage D. During the cancelled ERROR cycle D retires without taking A.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_valid  <= 1'b0;
            d_write  <= 1'b0;
            hwdata_q <= '0;
        end else if (advance) begin
            d_valid <= a_valid;
            d_write <= a_write;
            if (a_valid && a_write) begin
                hwdata_q <= a_wdata;
            end
        end else if (complete) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= complete;
            rsp_err_q   <= complete && resp_err;
            rsp_rdata_q <= (complete && !d_write) ? HRDATA : '0;
        end
    end

    always_comb begin
        HTRANS    = (a_valid && !cancel) ? TRANS_NONSEQ : TRANS_IDLE;
        HADDR     = a_addr;
        HWRITE    = a_write;
        HSIZE     = a_size;
        HBURST    = 3'b000;
        HPROT     = 4'b0011;
        HWDATA    = hwdata_q;
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = rsp_rdata_q;
        busy      = a_valid || d_valid;
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Testbench for ahb_cmd_master: a behavioural AHB slave with scripted wait
// states and ERROR responses, an in-order response model, and directed
// scenarios with hand-computed expectations.
module tb_ahb_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [1:0] a, input logic [2:0] sz);
        logic [31:0] m;
        if (sz == 3'b000)      m = 32'h0000_00FF << (8 * a);
        else if (sz == 3'b001) m = 32'h0000_FFFF << (16 * a[1]);
        else                   m = 32'hFFFF_FFFF;
        return (old & ~m) | (nw & m);
    endfunction

    // slave scripting: one address may take wait states, one may ERROR
    logic [31:0] ws_addr  = 32'hFFFF_FFFF;
    int          ws_cnt   = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    // bus values sampled mid-cycle, used by the slave at the next edge
    logic [1:0]  s_htrans;
    logic [31:0] s_haddr, s_hwdata;
    logic        s_hwrite;
    logic [2:0]  s_hsize;

    localparam int LOGN = 1024;
    logic [1:0]  htrans_log [LOGN];
    logic [31:0] haddr_log  [LOGN];
    logic [31:0] hwdata_log [LOGN];
    logic [2:0]  hsize_log  [LOGN];
    logic [31:0] rdata_log  [LOGN];
    logic        ready_log  [LOGN];
    logic        rspv_log   [LOGN];
    logic        rsperr_log [LOGN];
    int          rsp_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] mdl_mem [64];

    // ---------------- slave ----------------
    initial begin
        logic        dp_valid, dp_write;
        logic [31:0] dp_addr;
        logic [2:0]  dp_size;
        int          ws_left, err_ph;
        logic [31:0] smem [64];
        foreach (smem[i]) smem[i] = '0;
        dp_valid = 0; dp_write = 0; dp_addr = '0; dp_size = '0; ws_left = 0; err_ph = 0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'hBAD0_BAD0;
        forever begin
            @(posedge HCLK);
            if (!HRESETn) begin
                dp_valid = 0; ws_left = 0; err_ph = 0;
            end else if (HREADY) begin
                if (dp_valid && dp_write && HRESP == 2'b00)
                    smem[dp_addr[7:2]] = merge(smem[dp_addr[7:2]], s_hwdata, dp_addr[1:0], dp_size);
                dp_valid = 0;
                err_ph = 0;
                if (s_htrans == 2'b10) begin
                    dp_valid = 1; dp_addr = s_haddr; dp_write = s_hwrite; dp_size = s_hsize;
                    ws_left = (s_haddr == ws_addr) ? ws_cnt : 0;
                    err_ph  = (s_haddr == err_addr) ? 1 : 0;
                end
            end else begin
                if (err_ph == 1) err_ph = 2;
                else if (ws_left > 0) ws_left--;
            end
            #1;
            HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'hBAD0_BAD0;
            if (dp_valid) begin
                if (err_ph == 1) begin HREADY = 1'b0; HRESP = 2'b01; end
                else if (err_ph == 2) HRESP = 2'b01;
                else if (ws_left > 0) HREADY = 1'b0;
                else if (!dp_write) HRDATA = smem[dp_addr[7:2]];
            end
        end
    end

    // ---------------- monitor, model and per-cycle compare ----------------
    initial begin
        exp_t e;
        logic is_err;
        foreach (mdl_mem[i]) mdl_mem[i] = '0;
        forever begin
            @(negedge HCLK);
            s_htrans = HTRANS; s_haddr = HADDR; s_hwdata = HWDATA; s_hwrite = HWRITE; s_hsize = HSIZE;
            if (cyc < LOGN) begin
                htrans_log[cyc] = HTRANS; haddr_log[cyc] = HADDR; hwdata_log[cyc] = HWDATA;
                hsize_log[cyc] = HSIZE; rdata_log[cyc] = rsp_rdata; ready_log[cyc] = cmd_ready;
                rspv_log[cyc] = rsp_valid; rsperr_log[cyc] = rsp_err;
            end
            if (!HRESETn) begin
                exp_q.delete();
            end else begin
                chk("hburst", {29'd0, HBURST}, 32'd0);
                chk("hprot", {28'd0, HPROT}, 32'd3);
                chk("htrans_legal", {31'd0, (HTRANS == 2'b00 || HTRANS == 2'b10)}, 32'd1);
                if (rsp_valid) begin
                    rsp_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    is_err = (cmd_addr == err_addr);
                    e.err = is_err;
                    if (cmd_write) begin
                        e.rdata = '0;
                        if (!is_err)
                            mdl_mem[cmd_addr[7:2]] = merge(mdl_mem[cmd_addr[7:2]], cmd_wdata,
                                                           cmd_addr[1:0], cmd_size);
                    end else begin
                        e.rdata = is_err ? 32'hBAD0_BAD0 : mdl_mem[cmd_addr[7:2]];
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, output int acc);
        int n = 0;
        bit done = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
        acc = -1;
        while (!done) begin
            @(negedge HCLK);
            if (cmd_ready) begin
                acc = cyc;
                done = 1;
            end else if (++n > 50) begin
                failures++;
                $display("FAIL send_timeout: cmd_ready low for %0d cycles, required acceptance", n);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "command never accepted");
            end
        end
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int a, b, r, n, cnt0;
        int acc8 [8];
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;

        #12;
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #10 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // single write then read of the same word
        send(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, a);
        send(1'b0, 32'h10, 3'b010, 32'h0, b);
        idle(8);
        chk("t1_nonseq", {30'd0, htrans_log[a+1]}, 32'd2);
        chk("t1_haddr", haddr_log[a+1], 32'h10);
        chk("t1_hwdata", hwdata_log[a+2], 32'hDEAD_BEEF);
        chk("t1_rd_gap", {31'd0, rspv_log[b+2] & ~rspv_log[b+3]}, 32'd0);
        chk("t1_rd_rsp", {31'd0, rspv_log[b+3]}, 32'd1);
        chk("t1_rd_data", rdata_log[b+3], 32'hDEAD_BEEF);
        chk("t1_rd_err", {31'd0, rsperr_log[b+3]}, 32'd0);

        // eight back-to-back writes
        for (int i = 0; i < 8; i++) send(1'b1, 32'(4 * i), 3'b010, 32'h1000 + 32'(i), acc8[i]);
        send(1'b0, 32'h1C, 3'b010, 32'h0, r);
        idle(8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_accept_cycle", acc8[i], acc8[0] + i);
            chk("t2_nonseq", {30'd0, htrans_log[acc8[0]+1+i]}, 32'd2);
            chk("t2_haddr", haddr_log[acc8[0]+1+i], 32'(4 * i));
            chk("t2_hwdata", hwdata_log[acc8[0]+2+i], 32'h1000 + 32'(i));
            chk("t2_rsp", {31'd0, rspv_log[acc8[0]+3+i]}, 32'd1);
        end
        chk("t2_readback", rdata_log[r+3], 32'h1007);

        // read with two wait states, write pending behind it
        ws_addr = 32'h20; ws_cnt = 2;
        send(1'b0, 32'h20, 3'b010, 32'h0, a);
        send(1'b1, 32'h24, 3'b010, 32'h55, b);
        idle(8);
        ws_addr = 32'hFFFF_FFFF;
        chk("t3_accept_next", b, a + 1);
        for (int i = 2; i <= 4; i++) begin
            chk("t3_haddr_hold", haddr_log[a+i], 32'h24);
            chk("t3_hwdata_hold", hwdata_log[a+i], 32'h1007);
            chk("t3_nonseq_hold", {30'd0, htrans_log[a+i]}, 32'd2);
        end
        chk("t3_ready_ws1", {31'd0, ready_log[a+2]}, 32'd0);
        chk("t3_ready_ws2", {31'd0, ready_log[a+3]}, 32'd0);
        chk("t3_no_early_rsp", {31'd0, rspv_log[a+4]}, 32'd0);
        chk("t3_rsp_cycle5", {31'd0, rspv_log[a+5]}, 32'd1);
        chk("t3_follow_rsp", {31'd0, rspv_log[a+6]}, 32'd1);
        chk("t3_follow_wdata", hwdata_log[a+5], 32'h55);

        // two-cycle ERROR on a write with a pipelined read behind it
        err_addr = 32'h40;
        send(1'b1, 32'h40, 3'b010, 32'h77, a);
        send(1'b0, 32'h44, 3'b010, 32'h0, b);
        idle(10);
        err_addr = 32'hFFFF_FFFF;
        chk("t4_accept_next", b, a + 1);
        chk("t4_idle_2nd_err", {30'd0, htrans_log[a+3]}, 32'd0);
        chk("t4_err_rsp", {31'd0, rspv_log[a+4]}, 32'd1);
        chk("t4_err_flag", {31'd0, rsperr_log[a+4]}, 32'd1);
        chk("t4_reissue", {30'd0, htrans_log[a+4]}, 32'd2);
        chk("t4_reissue_addr", haddr_log[a+4], 32'h44);
        chk("t4_follow_rsp", {31'd0, rspv_log[a+6]}, 32'd1);
        chk("t4_follow_ok", {31'd0, rsperr_log[a+6]}, 32'd0);
        n = 0;
        for (int i = a + 1; i <= a + 9; i++) n += int'(rspv_log[i]);
        chk("t4_two_rsp", n, 32'd2);
        send(1'b0, 32'h40, 3'b010, 32'h0, r);
        idle(6);
        chk("t4_err_write_dropped", rdata_log[r+3], 32'h0);

        // byte write into the top lane of word 0
        send(1'b1, 32'h03, 3'b000, 32'hAA00_0000, a);
        send(1'b0, 32'h00, 3'b010, 32'h0, r);
        idle(6);
        chk("t5_hsize", {29'd0, hsize_log[a+1]}, 32'd0);
        chk("t5_haddr", haddr_log[a+1], 32'h03);
        chk("t5_hwdata", hwdata_log[a+2], 32'hAA00_0000);
        chk("t5_merged_word", rdata_log[r+3], 32'hAA00_1000);

        // reset while a read waits in its data phase
        ws_addr = 32'h80; ws_cnt = 5;
        send(1'b0, 32'h80, 3'b010, 32'h0, a);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("t6_busy_before", {31'd0, busy}, 32'd1);
        chk("t6_hready_low", {31'd0, HREADY}, 32'd0);
        cnt0 = rsp_cnt;
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_htrans", {30'd0, HTRANS}, 32'd0);
        chk("t6_haddr", HADDR, 32'd0);
        chk("t6_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("t6_hsize", {29'd0, HSIZE}, 32'd0);
        chk("t6_hwdata", HWDATA, 32'd0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        ws_addr = 32'hFFFF_FFFF;
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("t6_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("t6_idle_after", {31'd0, busy}, 32'd0);
        idle(8);
        chk("t6_no_rsp", rsp_cnt, cnt0);

        chk("pending_rsp", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
